// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: tracks instruction words and write/load flags through EX, MEM and WB,
// detects ID/EX load-use hazards and applies EX-resolved flushes. Optional macro: RD_ZERO_FILTER_EN.
module hazard_pipe_ctrl #(
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
   parameter bit          PRECISE_RS = 1'b1
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        en,
   input  logic [31:0] instruction_ID,
   input  logic        RegWrite_ID,
   input  logic        MemRead_ID,
   input  logic        branch_taken_EX,
   output logic [31:0] instruction_EX,
   output logic [31:0] instruction_MEM,
   output logic [31:0] instruction_WB,
   output logic        RegWrite_EX,
   output logic        RegWrite_MEM,
   output logic        RegWrite_WB,
   output logic        MemRead_EX,
   output logic        stall_IF_ID,
   output logic        flush_IF_ID
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   function automatic logic uses_rs1_f(input logic [6:0] op);
      logic r;
      if (PRECISE_RS) begin
         r = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
      end else begin
         r = 1'b1;
      end
      return r;
   endfunction

   function automatic logic uses_rs2_f(input logic [6:0] op);
      logic r;
      if (PRECISE_RS) begin
         r = (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
      end else begin
         r = 1'b1;
      end
      return r;
   endfunction

   logic [31:0] instr_ex_q, instr_ex_d;
   logic [31:0] instr_mem_q, instr_mem_d;
   logic [31:0] instr_wb_q, instr_wb_d;
   logic        regwrite_ex_q, regwrite_ex_d;
   logic        regwrite_mem_q, regwrite_mem_d;
   logic        regwrite_wb_q, regwrite_wb_d;
   logic        memread_ex_q, memread_ex_d;
   logic        load_use_s;
   logic        bubble_s;
   logic [4:0]  rd_ex_s;

   // Hazard detection and next-state selection; flush and stall both collapse to a bubble.
   always_comb begin
      rd_ex_s    = instr_ex_q[11:7];
      load_use_s = memread_ex_q && (rd_ex_s != 5'd0) &&
                   ((uses_rs1_f(instruction_ID[6:0]) && (instruction_ID[19:15] == rd_ex_s)) ||
                    (uses_rs2_f(instruction_ID[6:0]) && (instruction_ID[24:20] == rd_ex_s)));
      bubble_s   = branch_taken_EX || load_use_s;

      instr_mem_d    = instr_ex_q;
      regwrite_mem_d = regwrite_ex_q;
      instr_wb_d     = instr_mem_q;
      regwrite_wb_d  = regwrite_mem_q;
      if (bubble_s) begin
         instr_ex_d    = NOP_INSTR;
         regwrite_ex_d = 1'b0;
         memread_ex_d  = 1'b0;
      end else begin
         instr_ex_d    = instruction_ID;
         regwrite_ex_d = RegWrite_ID;
         memread_ex_d  = MemRead_ID;
      end
   end

   // Pipeline registers; everything holds while en is low.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         instr_ex_q     <= NOP_INSTR;
         instr_mem_q    <= NOP_INSTR;
         instr_wb_q     <= NOP_INSTR;
         regwrite_ex_q  <= 1'b0;
         regwrite_mem_q <= 1'b0;
         regwrite_wb_q  <= 1'b0;
         memread_ex_q   <= 1'b0;
      end else if (en) begin
         instr_ex_q     <= instr_ex_d;
         instr_mem_q    <= instr_mem_d;
         instr_wb_q     <= instr_wb_d;
         regwrite_ex_q  <= regwrite_ex_d;
         regwrite_mem_q <= regwrite_mem_d;
         regwrite_wb_q  <= regwrite_wb_d;
         memread_ex_q   <= memread_ex_d;
      end
   end

   assign flush_IF_ID     = branch_taken_EX && !arst;
   assign stall_IF_ID     = load_use_s && !branch_taken_EX && !arst;
   assign instruction_EX  = instr_ex_q;
   assign instruction_MEM = instr_mem_q;
   assign instruction_WB  = instr_wb_q;
   assign MemRead_EX      = memread_ex_q;

`ifdef RD_ZERO_FILTER_EN
   // Writes toward x0 are hidden so forwarding never selects x0 as a source.
   assign RegWrite_EX  = regwrite_ex_q  && (instr_ex_q[11:7]  != 5'd0);
   assign RegWrite_MEM = regwrite_mem_q && (instr_mem_q[11:7] != 5'd0);
   assign RegWrite_WB  = regwrite_wb_q  && (instr_wb_q[11:7]  != 5'd0);
`else
   assign RegWrite_EX  = regwrite_ex_q;
   assign RegWrite_MEM = regwrite_mem_q;
   assign RegWrite_WB  = regwrite_wb_q;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Scoreboard bench for hazard_pipe_ctrl: directed vectors carry hand-computed expectations,
// a negedge monitor pops and compares them. A second instance runs with PRECISE_RS=0.
module tb_hazard_pipe_ctrl;

   localparam logic [31:0] N = 32'h0000_0013; // nop
   localparam logic [31:0] A = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] B = 32'h0010_8133; // add  x2,x1,x1
   localparam logic [31:0] C = 32'h0021_A023; // sw   x2,0(x3)
   localparam logic [31:0] L = 32'h0000_A283; // lw   x5,0(x1)
   localparam logic [31:0] D = 32'h0002_8333; // add  x6,x5,x0
   localparam logic [31:0] U = 32'h0002_83B7; // lui  x7,0x28 (bits[19:15]=5)
   localparam logic [31:0] Z = 32'h0010_0013; // addi x0,x0,1
   localparam logic [31:0] S = 32'h0050_A023; // sw   x5,0(x1)
`ifdef RD_ZERO_FILTER_EN
   localparam logic RZ = 1'b0;
`else
   localparam logic RZ = 1'b1;
`endif

   typedef struct {
      logic arst, en; logic [31:0] id; logic rw, mr, br;
      logic [31:0] ex, mem, wb;
      logic rwex, rwmem, rwwb, mrex, stall, flush, stall0;
   } vec_t;

   logic clk = 1'b0;
   logic arst = 1'b1;
   logic en = 1'b1;
   logic [31:0] instruction_ID = N;
   logic RegWrite_ID = 1'b0, MemRead_ID = 1'b0, branch_taken_EX = 1'b0;
   logic [31:0] instruction_EX, instruction_MEM, instruction_WB;
   logic RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemRead_EX, stall_IF_ID, flush_IF_ID;
   logic [31:0] i_ex0, i_mem0, i_wb0;
   logic rw_ex0, rw_mem0, rw_wb0, mr_ex0, stall0, flush0;

   vec_t vecs[$];
   vec_t sb[$];
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_pipe_ctrl dut (
      .clk(clk), .arst(arst), .en(en), .instruction_ID(instruction_ID),
      .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .branch_taken_EX(branch_taken_EX),
      .instruction_EX(instruction_EX), .instruction_MEM(instruction_MEM),
      .instruction_WB(instruction_WB), .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM),
      .RegWrite_WB(RegWrite_WB), .MemRead_EX(MemRead_EX),
      .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID)
   );

   hazard_pipe_ctrl #(.PRECISE_RS(1'b0)) dut0 (
      .clk(clk), .arst(arst), .en(en), .instruction_ID(instruction_ID),
      .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .branch_taken_EX(branch_taken_EX),
      .instruction_EX(i_ex0), .instruction_MEM(i_mem0), .instruction_WB(i_wb0),
      .RegWrite_EX(rw_ex0), .RegWrite_MEM(rw_mem0), .RegWrite_WB(rw_wb0),
      .MemRead_EX(mr_ex0), .stall_IF_ID(stall0), .flush_IF_ID(flush0)
   );

   task automatic add(input logic ar, input logic e, input logic [31:0] id,
                      input logic rw, input logic mr, input logic br,
                      input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb,
                      input logic rwex, input logic rwmem, input logic rwwb, input logic mrex,
                      input logic st, input logic fl, input logic st0);
      vec_t v;
      v.arst = ar; v.en = e; v.id = id; v.rw = rw; v.mr = mr; v.br = br;
      v.ex = ex; v.mem = mem; v.wb = wb;
      v.rwex = rwex; v.rwmem = rwmem; v.rwwb = rwwb; v.mrex = mrex;
      v.stall = st; v.flush = fl; v.stall0 = st0;
      vecs.push_back(v);
   endtask

   task automatic chk(input int idx, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
      end
   endtask

   // Monitor: one expectation record per cycle, compared at the falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         automatic vec_t v = sb.pop_front();
         chk(n_vec, "instruction_EX", instruction_EX, v.ex);
         chk(n_vec, "instruction_MEM", instruction_MEM, v.mem);
         chk(n_vec, "instruction_WB", instruction_WB, v.wb);
         chk(n_vec, "RegWrite_EX", {31'd0, RegWrite_EX}, {31'd0, v.rwex});
         chk(n_vec, "RegWrite_MEM", {31'd0, RegWrite_MEM}, {31'd0, v.rwmem});
         chk(n_vec, "RegWrite_WB", {31'd0, RegWrite_WB}, {31'd0, v.rwwb});
         chk(n_vec, "MemRead_EX", {31'd0, MemRead_EX}, {31'd0, v.mrex});
         chk(n_vec, "stall_IF_ID", {31'd0, stall_IF_ID}, {31'd0, v.stall});
         chk(n_vec, "flush_IF_ID", {31'd0, flush_IF_ID}, {31'd0, v.flush});
         chk(n_vec, "stall_IF_ID(PRECISE_RS=0)", {31'd0, stall0}, {31'd0, v.stall0});
         n_vec++;
      end
   end

   initial begin
      //   arst en id rw mr br | ex mem wb | rwex rwmem rwwb mrex | stall flush stall0
      add(1'b1, 1'b1, N, 1'b0, 1'b0, 1'b1, N, N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 1'b1, 1'b0, 1'b0, N, N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, B, 1'b1, 1'b0, 1'b0, A, N, N, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, C, 1'b0, 1'b0, 1'b0, B, A, N, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, N, 1'b0, 1'b0, 1'b0, C, B, A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, L, 1'b1, 1'b1, 1'b0, N, C, B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      // load-use on rs1: one stall, bubble, then add enters EX
      add(1'b0, 1'b1, D, 1'b1, 1'b0, 1'b0, L, N, C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      add(1'b0, 1'b1, D, 1'b1, 1'b0, 1'b0, N, L, N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, N, 1'b0, 1'b0, 1'b0, D, N, L, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, L, 1'b1, 1'b1, 1'b0, N, D, N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // flush coinciding with load-use: flush wins, no stall
      add(1'b0, 1'b1, D, 1'b1, 1'b0, 1'b1, L, N, D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, N, 1'b0, 1'b0, 1'b0, N, L, N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, L, 1'b1, 1'b1, 1'b0, N, N, L, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      // lui whose imm bits alias rs1=x5: only the imprecise instance stalls
      add(1'b0, 1'b1, U, 1'b1, 1'b0, 1'b0, L, N, N, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, Z, 1'b1, 1'b0, 1'b0, U, L, N, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, N, 1'b0, 1'b0, 1'b0, Z, U, L, RZ,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      // en=0 for three cycles: state frozen, flush still follows its input
      add(1'b0, 1'b0, N, 1'b0, 1'b0, 1'b0, N, Z, U, 1'b0, RZ,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, A, 1'b1, 1'b0, 1'b1, N, Z, U, 1'b0, RZ,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b0, A, 1'b1, 1'b0, 1'b0, N, Z, U, 1'b0, RZ,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, N, 1'b0, 1'b0, 1'b0, N, Z, U, 1'b0, RZ,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, L, 1'b1, 1'b1, 1'b0, N, N, Z, 1'b0, 1'b0, RZ,   1'b0, 1'b0, 1'b0, 1'b0);
      // reset while a load-use would stall: state clears at once, no stall or flush
      add(1'b1, 1'b1, D, 1'b1, 1'b0, 1'b1, N, N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, D, 1'b1, 1'b0, 1'b0, N, N, N, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, N, 1'b0, 1'b0, 1'b0, D, N, N, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // load-use through rs2 of a store
      add(1'b0, 1'b1, L, 1'b1, 1'b1, 1'b0, N, D, N, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, S, 1'b0, 1'b0, 1'b0, L, N, D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         arst            = vecs[i].arst;
         en              = vecs[i].en;
         instruction_ID  = vecs[i].id;
         RegWrite_ID     = vecs[i].rw;
         MemRead_ID      = vecs[i].mr;
         branch_taken_EX = vecs[i].br;
         sb.push_back(vecs[i]);
      end
      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() != 0 || n_vec != vecs.size()) begin
         n_bad++;
         $display("FAIL drain: checked %0d vectors, expected %0d", n_vec, vecs.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
